// File: rtl/mic_frame_packer.sv
// mic_frame_packer: rounds/saturates per-mic 32-bit words to 16-bit samples and packs
// each in-order 4-mic group into one 64-bit beat, flagging and counting index errors.
module mic_frame_packer #(
  parameter int SAMPLE_MSB = 31,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [31:0]          s_axis_tdata,
  input  logic [1:0]           s_axis_tuser,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [63:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] seq_err_cnt
);
  typedef enum logic [1:0] {EXP0, EXP1, EXP2, EXP3} state_t;
  state_t idx, idx_nxt;
  logic [2:0][15:0] slots;
  logic sticky, acc, hit, load;
  logic signed [16:0] x;
  logic signed [17:0] r;
  logic [15:0] sample;
  logic unused_bits;
  assign unused_bits = ^s_axis_tdata;
  assign x = s_axis_tdata[SAMPLE_MSB -: 17];
  assign r = ($signed({x[16], x}) + 18'sd1) >>> 1;
  assign sample = r > 18'sd32767 ? 16'h7fff : r[15:0];
  // only the group-completing beat can stall, and only while the output register is stuck
  assign s_axis_tready = !areset && !(idx == EXP3 && m_axis_tvalid && !m_axis_tready);
  assign acc = s_axis_tvalid && s_axis_tready;
  assign hit = s_axis_tuser == idx;
  assign load = acc && hit && idx == EXP3;
  always_comb idx_nxt = !acc ? idx : hit ? state_t'(idx + 2'd1) : s_axis_tuser == 2'd0 ? EXP1 : EXP0;
  always_ff @(posedge aclk) idx <= areset ? EXP0 : idx_nxt;
  always_ff @(posedge aclk) begin
    if (areset) begin
      slots <= '0;
      sticky <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      seq_err <= 1'b0;
      seq_err_cnt <= '0;
    end else begin
      seq_err <= acc && !hit;
      if (acc && !hit && ~&seq_err_cnt) seq_err_cnt <= seq_err_cnt + 1'b1;
      // a misordered mic-0 beat restarts the group rather than being dropped
      if (acc && s_axis_tuser != 2'd3 && (hit || s_axis_tuser == 2'd0)) slots[s_axis_tuser] <= sample;
      if (load) sticky <= 1'b0;
      else if (acc) sticky <= sticky | s_axis_tlast;
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata <= {sample, slots};
        m_axis_tlast <= sticky | s_axis_tlast;
      end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
    end
  end
endmodule
